// File: rtl/l1_cache_controller_pkg.sv
// Shared constants, address field layout and FSM state type for the L1 cache controller.
package l1_cache_controller_pkg;

    localparam int unsigned NUM_SETS      = 64;
    localparam int unsigned NUM_WAYS      = 2;
    localparam int unsigned LINE_BITS     = 512;
    localparam int unsigned WORD_BITS     = 32;

    // Byte address layout: tag | set | word | byte
    localparam int unsigned TAG_MSB       = 31;
    localparam int unsigned TAG_LSB       = 12;
    localparam int unsigned TAG_BITS      = TAG_MSB - TAG_LSB + 1;
    localparam int unsigned SET_MSB       = 11;
    localparam int unsigned SET_LSB       = 6;
    localparam int unsigned SET_BITS      = SET_MSB - SET_LSB + 1;
    localparam int unsigned WORD_MSB      = 5;
    localparam int unsigned WORD_LSB      = 2;
    localparam int unsigned WORD_IDX_BITS = WORD_MSB - WORD_LSB + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_MISS  = 2'd1,
        WRITE_THRU = 2'd2
    } state_e;

endpackage

// File: rtl/l1_cache_controller_cache_mem.sv
// Line data array: 64 sets x 2 ways x 512 bits, combinational read of both ways,
// full-line write for refills and single-word write for write hits.
module l1_cache_controller_cache_mem
    import l1_cache_controller_pkg::*;
(
    input  logic                     clk,
    input  logic [SET_BITS-1:0]      rd_set,
    output logic [LINE_BITS-1:0]     rd_line0,
    output logic [LINE_BITS-1:0]     rd_line1,
    input  logic [SET_BITS-1:0]      wr_set,
    input  logic                     line_we,
    input  logic                     line_way,
    input  logic [LINE_BITS-1:0]     line_wdata,
    input  logic                     word_we,
    input  logic                     word_way,
    input  logic [WORD_IDX_BITS-1:0] word_idx,
    input  logic [WORD_BITS-1:0]     word_wdata
);

    logic [LINE_BITS-1:0] mem [NUM_SETS][NUM_WAYS];

    assign rd_line0 = mem[rd_set][0];
    assign rd_line1 = mem[rd_set][1];

    // Refill writes a whole line; a write hit patches one word. Never both in one cycle.
    always_ff @(posedge clk) begin
        if (line_we) begin
            mem[wr_set][line_way] <= line_wdata;
        end else if (word_we) begin
            mem[wr_set][word_way][{word_idx, 5'b0} +: WORD_BITS] <= word_wdata;
        end
    end

endmodule

// File: rtl/l1_cache_controller.sv
// 2-way set-associative write-through, no-write-allocate L1 cache controller.
// Tags, valid and LRU bits plus the request FSM live here; line data lives in cache_mem.
module l1_cache_controller
    import l1_cache_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,  // active-high despite the name
    input  logic [31:0]          phy_addr,
    input  logic [31:0]          data_from_cpu,
    input  logic                 read_mem,
    input  logic                 write_mem,
    output logic [31:0]          data_to_cpu,
    output logic                 hit_miss,
    output logic                 ready_stall,
    output logic [31:0]          main_mem_addr,
    output logic [31:0]          main_mem_data_out,
    output logic                 main_mem_read_req,
    output logic                 main_mem_write_req,
    input  logic [LINE_BITS-1:0] main_mem_data_in,
    input  logic                 main_mem_ready
);

    state_e                     state_q, state_d;
    logic [NUM_WAYS-1:0]        valid_q [NUM_SETS];
    logic [TAG_BITS-1:0]        tag_q [NUM_SETS][NUM_WAYS];
    logic [NUM_SETS-1:0]        lru_q;
    logic [31:0]                data_q, addr_q, wdata_q;
    logic                       hit_q;
    logic [WORD_IDX_BITS-1:0]   word_q;

    logic [TAG_BITS-1:0]        req_tag, miss_tag;
    logic [SET_BITS-1:0]        req_set, miss_set;
    logic [WORD_IDX_BITS-1:0]   req_word;
    logic [LINE_BITS-1:0]       line0, line1, hit_line;
    logic                       hit0, hit1, hit, hit_way, victim;
    logic                       accept_rd, accept_wr, fill;
    logic [31:0]                rd_word, fill_word;

    assign req_tag  = phy_addr[TAG_MSB:TAG_LSB];
    assign req_set  = phy_addr[SET_MSB:SET_LSB];
    assign req_word = phy_addr[WORD_MSB:WORD_LSB];
    assign miss_tag = addr_q[TAG_MSB:TAG_LSB];
    assign miss_set = addr_q[SET_MSB:SET_LSB];

    assign hit0     = valid_q[req_set][0] && (tag_q[req_set][0] == req_tag);
    assign hit1     = valid_q[req_set][1] && (tag_q[req_set][1] == req_tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_line = hit0 ? line0 : line1;
    assign rd_word  = hit_line[{req_word, 5'b0} +: WORD_BITS];
    assign fill_word = main_mem_data_in[{word_q, 5'b0} +: WORD_BITS];

    // Victim choice: first invalid way, otherwise the way named by the LRU bit.
    always_comb begin
        victim = lru_q[miss_set];
        if (!valid_q[miss_set][0]) begin
            victim = 1'b0;
        end else if (!valid_q[miss_set][1]) begin
            victim = 1'b1;
        end
    end

    // Next state and per-edge action strobes.
    always_comb begin
        state_d   = state_q;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        fill      = 1'b0;
        case (state_q)
            IDLE: begin
                if (read_mem) begin
                    accept_rd = 1'b1;
                    state_d   = hit ? IDLE : READ_MISS;
                end else if (write_mem) begin
                    accept_wr = 1'b1;
                    state_d   = WRITE_THRU;
                end
            end
            READ_MISS: begin
                if (main_mem_ready) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE_THRU: begin
                if (main_mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, valid/LRU bits and the registered CPU/memory outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_SETS; i++) begin
                valid_q[i] <= '0;
            end
            lru_q   <= '0;
            data_q  <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_rd || accept_wr) begin
                hit_q <= hit;
            end
            if (accept_rd && hit) begin
                data_q         <= rd_word;
                lru_q[req_set] <= ~hit_way;
            end
            if (accept_rd && !hit) begin
                addr_q <= {phy_addr[31:6], 6'b0};
                word_q <= req_word;
            end
            if (accept_wr) begin
                addr_q  <= phy_addr;
                wdata_q <= data_from_cpu;
                if (hit) begin
                    lru_q[req_set] <= ~hit_way;
                end
            end
            if (fill) begin
                valid_q[miss_set][victim] <= 1'b1;
                lru_q[miss_set]           <= ~victim;
                data_q                    <= fill_word;
            end
        end
    end

    // Tags need no reset; they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[miss_set][victim] <= miss_tag;
        end
    end

    l1_cache_controller_cache_mem cache_mem (
        .clk        (clk),
        .rd_set     (req_set),
        .rd_line0   (line0),
        .rd_line1   (line1),
        .wr_set     (fill ? miss_set : req_set),
        .line_we    (fill),
        .line_way   (victim),
        .line_wdata (main_mem_data_in),
        .word_we    (accept_wr && hit),
        .word_way   (hit_way),
        .word_idx   (req_word),
        .word_wdata (data_from_cpu)
    );

    assign data_to_cpu        = data_q;
    assign hit_miss           = hit_q;
    assign ready_stall        = (state_q != IDLE);
    assign main_mem_read_req  = (state_q == READ_MISS);
    assign main_mem_write_req = (state_q == WRITE_THRU);
    assign main_mem_addr      = addr_q;
    assign main_mem_data_out  = wdata_q;

endmodule

// File: tb/tb_l1_cache_controller.sv
// Randomized bench for l1_cache_controller against a recency-list cache model and a
// word-addressed main-memory model; the bench itself plays main memory.
module tb_l1_cache_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  phy_addr, data_from_cpu;
    logic         read_mem, write_mem;
    logic [31:0]  data_to_cpu;
    logic         hit_miss, ready_stall;
    logic [31:0]  main_mem_addr, main_mem_data_out;
    logic         main_mem_read_req, main_mem_write_req;
    logic [511:0] main_mem_data_in;
    logic         main_mem_ready;

    always #5 clk = ~clk;

    l1_cache_controller dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .phy_addr           (phy_addr),
        .data_from_cpu      (data_from_cpu),
        .read_mem           (read_mem),
        .write_mem          (write_mem),
        .data_to_cpu        (data_to_cpu),
        .hit_miss           (hit_miss),
        .ready_stall        (ready_stall),
        .main_mem_addr      (main_mem_addr),
        .main_mem_data_out  (main_mem_data_out),
        .main_mem_read_req  (main_mem_read_req),
        .main_mem_write_req (main_mem_write_req),
        .main_mem_data_in   (main_mem_data_in),
        .main_mem_ready     (main_mem_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Main memory: explicitly written words, otherwise an address-derived pattern.
    bit [31:0] mem_model [bit [29:0]];
    // Cache model per set: resident tags ordered by recency (2-way LRU).
    int unsigned nvalid [64];
    bit [19:0]   mru_t  [64];
    bit [19:0]   lru_t  [64];
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a[31:2])) return mem_model[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'h3C3C_A5A5;
    endfunction

    function automatic logic [511:0] build_line(input logic [31:0] a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) begin
            l[i*32 +: 32] = mem_rd({a[31:6], 6'b0} + 32'(i * 4));
        end
        return l;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int s = int'(a[11:6]);
        return (nvalid[s] >= 1 && mru_t[s] == a[31:12]) ||
               (nvalid[s] == 2 && lru_t[s] == a[31:12]);
    endfunction

    task automatic model_touch(input logic [31:0] a);
        int s = int'(a[11:6]);
        if (mru_t[s] != a[31:12]) begin
            lru_t[s] = mru_t[s];
            mru_t[s] = a[31:12];
        end
    endtask

    task automatic model_fill(input logic [31:0] a);
        int s = int'(a[11:6]);
        if (nvalid[s] != 0) lru_t[s] = mru_t[s];
        mru_t[s] = a[31:12];
        if (nvalid[s] < 2) nvalid[s]++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) nvalid[i] = 0;
        last_data = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, data_to_cpu, 32'h0);
        check({tag, "_hit"}, {31'b0, hit_miss}, 32'h0);
        check({tag, "_stall"}, {31'b0, ready_stall}, 32'h0);
        check({tag, "_rdreq"}, {31'b0, main_mem_read_req}, 32'h0);
        check({tag, "_wrreq"}, {31'b0, main_mem_write_req}, 32'h0);
        check({tag, "_addr"}, main_mem_addr, 32'h0);
        check({tag, "_dout"}, main_mem_data_out, 32'h0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
    endtask

    // Read; optionally with write_mem also high to exercise read priority.
    task automatic do_read(input logic [31:0] a, input bit both);
        bit h = model_hit(a);
        logic [31:0] exp = mem_rd(a);
        @(negedge clk);
        phy_addr = a; read_mem = 1'b1; write_mem = both; data_from_cpu = $urandom;
        @(posedge clk);
        #1 read_mem = 1'b0; write_mem = 1'b0;
        check("rd_hitmiss", {31'b0, hit_miss}, {31'b0, h});
        check("rd_wrreq", {31'b0, main_mem_write_req}, 32'h0);
        if (h) begin
            check("rd_hit_stall", {31'b0, ready_stall}, 32'h0);
            check("rd_hit_rdreq", {31'b0, main_mem_read_req}, 32'h0);
            check("rd_hit_data", data_to_cpu, exp);
            model_touch(a);
        end else begin
            check("rd_miss_stall", {31'b0, ready_stall}, 32'h1);
            check("rd_miss_rdreq", {31'b0, main_mem_read_req}, 32'h1);
            check("rd_miss_addr", main_mem_addr, {a[31:6], 6'b0});
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                phy_addr = $urandom; write_mem = 1'($urandom); read_mem = 1'($urandom);
                @(posedge clk);
                #1 check("rd_miss_hold", {31'b0, main_mem_read_req}, 32'h1);
            end
            @(negedge clk);
            read_mem = 1'b0; write_mem = 1'b0; phy_addr = a;
            main_mem_data_in = build_line(a); main_mem_ready = 1'b1;
            @(posedge clk);
            #1 main_mem_ready = 1'b0;
            check("rd_fill_stall", {31'b0, ready_stall}, 32'h0);
            check("rd_fill_rdreq", {31'b0, main_mem_read_req}, 32'h0);
            check("rd_fill_data", data_to_cpu, exp);
            model_fill(a);
        end
        last_data = exp;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bit h = model_hit(a);
        @(negedge clk);
        phy_addr = a; data_from_cpu = d; write_mem = 1'b1;
        @(posedge clk);
        #1 write_mem = 1'b0;
        check("wr_hitmiss", {31'b0, hit_miss}, {31'b0, h});
        check("wr_stall", {31'b0, ready_stall}, 32'h1);
        check("wr_wrreq", {31'b0, main_mem_write_req}, 32'h1);
        check("wr_rdreq", {31'b0, main_mem_read_req}, 32'h0);
        check("wr_addr", main_mem_addr, a);
        check("wr_dout", main_mem_data_out, d);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            read_mem = 1'($urandom); data_from_cpu = $urandom; phy_addr = $urandom;
            @(posedge clk);
            #1 check("wr_hold", {31'b0, main_mem_write_req}, 32'h1);
        end
        @(negedge clk);
        read_mem = 1'b0; main_mem_ready = 1'b1;
        @(posedge clk);
        #1 main_mem_ready = 1'b0;
        mem_model[a[31:2]] = d;
        if (h) model_touch(a);
        check("wr_done_stall", {31'b0, ready_stall}, 32'h0);
        check("wr_done_wrreq", {31'b0, main_mem_write_req}, 32'h0);
        check("wr_done_data", data_to_cpu, last_data);
    endtask

    task automatic stray_ready();
        @(negedge clk);
        main_mem_data_in = {16{$urandom}}; main_mem_ready = 1'b1;
        @(posedge clk);
        #1 main_mem_ready = 1'b0;
        check("stray_stall", {31'b0, ready_stall}, 32'h0);
        check("stray_rdreq", {31'b0, main_mem_read_req}, 32'h0);
        check("stray_data", data_to_cpu, last_data);
    endtask

    task automatic reset_mid_miss(input logic [31:0] a);
        @(negedge clk);
        phy_addr = a; read_mem = 1'b1;
        @(posedge clk);
        #1 read_mem = 1'b0;
        check("mid_stall", {31'b0, ready_stall}, {31'b0, !model_hit(a)});
        reset_pulse();
    endtask

    initial begin
        logic [31:0] a;
        int op;
        rst_n = 1'b1; phy_addr = '0; data_from_cpu = '0; read_mem = 1'b0; write_mem = 1'b0;
        main_mem_data_in = '0; main_mem_ready = 1'b0;
        model_clear();
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;

        mem_model[30'h0000_1040 >> 2] = 32'hA5A5_A5A5;
        do_read(32'h0000_1040, 1'b0);
        check("cold_read_value", data_to_cpu, 32'hA5A5_A5A5);
        do_read(32'h0000_1040, 1'b0);
        check("warm_read_hit", {31'b0, hit_miss}, 32'h1);
        do_write(32'h0000_1044, 32'hDEAD_BEEF);
        do_read(32'h0000_1044, 1'b0);
        check("write_hit_readback", data_to_cpu, 32'hDEAD_BEEF);
        do_read(32'h0000_0040, 1'b0);
        do_read(32'h0000_1040, 1'b0);
        do_read(32'h0000_2040, 1'b0);
        do_read(32'h0000_0040, 1'b0);
        check("evicted_misses", {31'b0, hit_miss}, 32'h0);
        do_read(32'h0000_2040, 1'b0);
        check("survivor_hits", {31'b0, hit_miss}, 32'h1);

        reset_pulse();
        do_write(32'h0000_3000, 32'h1234_5678);
        do_read(32'h0000_3000, 1'b0);
        check("no_alloc_readback", data_to_cpu, 32'h1234_5678);

        do_read(32'h0000_1040, 1'b0);
        reset_mid_miss(32'h0000_5040);
        do_read(32'h0000_1040, 1'b0);
        check("post_reset_miss", {31'b0, hit_miss}, 32'h0);

        for (int n = 0; n < 400; n++) begin
            a  = {18'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 3)),
                  4'($urandom), 2'($urandom)};
            op = $urandom_range(0, 99);
            if (op < 50)      do_read(a, 1'($urandom));
            else if (op < 85) do_write(a, $urandom);
            else if (op < 97) stray_ready();
            else              reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/l1_cache_controller.md
L1_CACHE_CONTROLLER -- requirements
Module: l1_cache_controller

Interface
REQ-001 Parameters (name, default, meaning), fixed values, not overridable: NUM_SETS, 64, sets; NUM_WAYS, 2, associativity; LINE_BITS, 512, line size (16 x 32-bit words).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-high reset (named as in codebase despite suffix).
REQ-004 phy_addr  input  32  CPU byte address; tag [31:12], set [11:6], word [5:2], [1:0] ignored.
REQ-005 data_from_cpu  input  32  CPU write data.
REQ-006 read_mem / write_mem  input  1 each  CPU read / write request strobes.
REQ-007 data_to_cpu  output  32  read data, registered.
REQ-008 hit_miss  output  1  1 = last accepted request hit, 0 = miss.
REQ-009 ready_stall  output  1  1 = busy, CPU must wait.
REQ-010 main_mem_addr  output  32  memory address.
REQ-011 main_mem_data_out  output  32  write-through word.
REQ-012 main_mem_read_req / main_mem_write_req  output  1 each  level requests.
REQ-013 main_mem_data_in  input  512  fetched line.
REQ-014 main_mem_ready  input  1  one-cycle completion pulse.

Function
REQ-015 2-way set-associative, 64 sets, 64-byte lines; per way per set: valid bit, 20-bit tag, 512-bit data; one LRU bit per set naming the victim way.
REQ-016 FSM states IDLE, READ_MISS, WRITE_THRU; requests accepted only in IDLE (ignored otherwise); read_mem has priority when both asserted.
REQ-017 Hit = valid and tag match in either way, evaluated combinationally on phy_addr; hit_miss registered at the accepting edge, held until next accepted request.
REQ-018 Read hit: data_to_cpu = addressed word at accepting edge; ready_stall stays 0; LRU set to the other way; no memory traffic.
REQ-019 Read miss: at accepting edge go READ_MISS, ready_stall=1, main_mem_read_req=1, main_mem_addr = {phy_addr[31:6],6'b0}; request held until main_mem_ready sampled high.
REQ-020 On ready in READ_MISS: victim = way0 if invalid, else way1 if invalid, else LRU way; write main_mem_data_in, tag, valid=1; LRU = other way; data_to_cpu = addressed word of fetched line; ready_stall=0, request dropped, return IDLE, same edge.
REQ-021 Write (write-through, no-write-allocate): at accepting edge go WRITE_THRU, ready_stall=1, main_mem_write_req=1, main_mem_addr = phy_addr, main_mem_data_out = data_from_cpu, held until main_mem_ready.
REQ-022 Write hit additionally updates the addressed 32-bit word of the hit way at accepting edge and sets LRU to the other way; write miss leaves cache unchanged.
REQ-023 On ready in WRITE_THRU: drop request, ready_stall=0, IDLE; data_to_cpu unchanged.
REQ-024 main_mem_ready outside a pending request is ignored; requests deasserted in IDLE.

Reset
REQ-025 rst_n high asynchronously: state IDLE, all valid and LRU bits 0, data_to_cpu=0, hit_miss=0, ready_stall=0, both memory requests 0, main_mem_addr=0, main_mem_data_out=0; an in-flight miss/write is abandoned with no cache update.
REQ-026 Data array contents need not be reset.

Structure
REQ-027 Shared package holds address field widths/positions, NUM_SETS, NUM_WAYS, LINE_BITS and the FSM state enum.
REQ-028 Data array is one sub-module cache_mem (64 x 2 x 512-bit, per-way line write and word write, combinational read); tags/valid/LRU and FSM in top.

Verification
REQ-029 Memory word 0x00001040 = 0xA5A5A5A5, after reset R 0x00001040 -> hit_miss=0, ready_stall=1, read_req with addr 0x00001040 until ready, then data_to_cpu=0xA5A5A5A5, ready_stall=0.
REQ-030 Repeat R 0x00001040 -> hit_miss=1, ready_stall stays 0, no read_req, data_to_cpu=0xA5A5A5A5.
REQ-031 W 0x00001044 0xDEADBEEF -> hit_miss=1, write_req addr 0x00001044 data 0xDEADBEEF; then R 0x00001044 -> hit, 0xDEADBEEF.
REQ-032 R 0x00000040, 0x00001040, 0x00002040 (set 1) -> third misses and evicts tag 0x00000; R 0x00000040 -> miss; R 0x00002040 -> hit.
REQ-033 W 0x00003000 0x12345678 after reset -> miss, memory written, no allocation; R 0x00003000 -> miss, returns 0x12345678.
REQ-034 Reset asserted mid read-miss -> all outputs 0 immediately; prior line then misses again.
